probe_capture: RTL

Parametrised in-fabric capture buffer for internal debug probes, the self-contained successor to the vendor JTAG analyser core. It samples a WIDTH-bit probe bus on qualified clock enables, keeps a configurable pre-trigger history, and stops after the post-trigger window. The stored window is then streamed out oldest-first over a simple read handshake to the UART/shift-register readout logic. It sits beside the display/ADC datapath and needs no vendor IP or JTAG chain.

---
 rtl/probe_capture.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/probe_capture.sv
// probe_capture: in-fabric capture buffer for internal debug probes.
//
// Samples a WIDTH-bit probe bus on qualified cycles (sample_en), keeps
// PRE_TRIG samples of history before a mask/value trigger, then fills
// the remaining DEPTH-PRE_TRIG entries and stops. The stored window is
// streamed out oldest-first with a one-cycle-latency read handshake.
//
// Optional feature: define PROBE_CAPTURE_TIMESTAMP_EN to store a 16-bit
// count of qualified samples since arm with every word; rd_data is then
// {timestamp, probe}, WIDTH+16 bits wide.
//
// Parameters:
//   WIDTH     probe bus width (1..64)
//   DEPTH     stored samples, power of two (8..4096)
//   PRE_TRIG  samples kept before the trigger (0 .. DEPTH-1)
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   sample_en   sample qualifier; capture advances only when 1
//   probe       signals under observation
//   arm         one-cycle pulse, (re)starts a capture from any state
//   trig_mask   1 = bit takes part in the trigger compare
//   trig_value  trigger compare value
//   trig_edge   0 = level trigger, 1 = rising edge of match
//   armed       capture in progress
//   triggered   trigger accepted for the current capture
//   done        window complete, readout available
//   rd_en       request next stored sample
//   rd_data     sample data (timestamp in the top 16 bits when enabled)
//   rd_valid    rd_data valid, one-cycle pulse
//   rd_last     marks the final (DEPTH-th) sample

module probe_capture #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned PRE_TRIG = 32,
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    localparam int unsigned DW      = WIDTH + 16
`else
    localparam int unsigned DW      = WIDTH
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] probe,
    input  logic             arm,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic             trig_edge,
    output logic             armed,
    output logic             triggered,
    output logic             done,
    input  logic             rd_en,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    output logic             rd_last
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Terminal values of the phase counter in PRETRIG and POST.
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
    localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPretrig,
        StWait,
        StPost,
        StDone
    } state_e;

    state_e           state_q;
    logic             armed_q;
    logic             triggered_q;
    logic             done_q;
    logic             rd_valid_q;
    logic             rd_last_q;
    logic [DW-1:0]    rd_data_q;

    logic [WIDTH-1:0] sample_q;
    logic             sample_vld_q;
    logic             prev_match_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    trig_addr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_cnt_q;
    logic [CW-1:0]    count_q;

    logic [DW-1:0]    mem [DEPTH];

    logic             capturing;
    logic             take_sample;
    logic             process;
    logic             match;
    logic             trig_hit;
    logic             wr_en;
    logic             rd_fire;
    logic [DW-1:0]    wr_data;

    // Compare runs on the registered sample, so it lines up with the write
    // of that same sample one cycle after it was taken.
    always_comb begin
        capturing   = (state_q == StPretrig) || (state_q == StWait) || (state_q == StPost);
        take_sample = sample_en && capturing && !arm;
        process     = sample_vld_q && capturing;
        match       = ((sample_q ^ trig_value) & trig_mask) == '0;
        trig_hit    = trig_edge ? (match && !prev_match_q) : match;
        wr_en       = process && !arm;
        rd_fire     = (state_q == StDone) && rd_en && !arm;
    end

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    logic [15:0] ts_cnt_q;
    logic [15:0] sample_ts_q;

    // Timestamp travels with its sample through the input register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt_q    <= '0;
            sample_ts_q <= '0;
        end else if (arm) begin
            ts_cnt_q    <= '0;
        end else if (take_sample) begin
            sample_ts_q <= ts_cnt_q;
            ts_cnt_q    <= ts_cnt_q + 16'd1;
        end
    end

    assign wr_data = {sample_ts_q, sample_q};
`else
    assign wr_data = sample_q;
`endif

    // Storage has no reset; every readable address is rewritten by a
    // complete capture before done is raised.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            prev_match_q <= 1'b1;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            count_q      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;

            if (arm) begin
                // Restart from any state; a same-cycle read and any sample
                // still in the input register are dropped.
                state_q      <= (PRE_TRIG == 0) ? StWait : StPretrig;
                armed_q      <= 1'b1;
                triggered_q  <= 1'b0;
                done_q       <= 1'b0;
                sample_vld_q <= 1'b0;
                prev_match_q <= 1'b1;
                wr_ptr_q     <= '0;
                count_q      <= '0;
            end else begin
                sample_vld_q <= take_sample;
                if (take_sample) begin
                    sample_q <= probe;
                end

                if (process) begin
                    wr_ptr_q     <= wr_ptr_q + AW'(1);
                    prev_match_q <= match;
                    case (state_q)
                        StPretrig: begin
                            if (count_q == PRE_LAST) begin
                                state_q <= StWait;
                                count_q <= '0;
                            end else begin
                                count_q <= count_q + CW'(1);
                            end
                        end
                        StWait: begin
                            if (trig_hit) begin
                                trig_addr_q <= wr_ptr_q;
                                triggered_q <= 1'b1;
                                // Trigger sample is post-sample 1.
                                if (POST_LAST == '0) begin
                                    state_q  <= StDone;
                                    armed_q  <= 1'b0;
                                    done_q   <= 1'b1;
                                    rd_ptr_q <= wr_ptr_q - PRE_OFF;
                                    rd_cnt_q <= '0;
                                end else begin
                                    state_q  <= StPost;
                                    count_q  <= CW'(1);
                                end
                            end
                        end
                        StPost: begin
                            if (count_q == POST_LAST) begin
                                state_q  <= StDone;
                                armed_q  <= 1'b0;
                                done_q   <= 1'b1;
                                rd_ptr_q <= trig_addr_q - PRE_OFF;
                                rd_cnt_q <= '0;
                            end else begin
                                count_q <= count_q + CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end

                if (rd_fire) begin
                    rd_data_q  <= mem[rd_ptr_q];
                    rd_valid_q <= 1'b1;
                    rd_ptr_q   <= rd_ptr_q + AW'(1);
                    rd_cnt_q   <= rd_cnt_q + AW'(1);
                    if (rd_cnt_q == RD_LAST) begin
                        rd_last_q <= 1'b1;
                        state_q   <= StIdle;
                        done_q    <= 1'b0;
                    end
                end
            end
        end
    end

    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;

endmodule
